// File: rtl/mouse_pkg.sv
// ============================================================================
// mouse_pkg : PS/2 mouse packet field positions and delta decode helpers
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package mouse_pkg;

  localparam int TOG_BIT = 24;
  localparam int Y_LSB   = 16;
  localparam int X_LSB   = 8;
  localparam int SX_BIT  = 4;
  localparam int SY_BIT  = 5;
  localparam int OX_BIT  = 6;
  localparam int OY_BIT  = 7;

  typedef logic signed [8:0] delta_t;

  // An overflowed axis reports the largest movement in the direction of its sign bit.
  function automatic delta_t decode_axis(input logic [7:0] mag, input logic sgn,
                                         input logic ovf);
    if (ovf) begin
      return sgn ? 9'h100 : 9'h0FF;
    end
    return {sgn, mag};
  endfunction

  function automatic delta_t negate_clamp(input delta_t d);
    logic signed [9:0] n;
    n = -$signed({d[8], d});
    if (n > 10'sd255) begin
      return 9'h0FF;
    end
    return n[8:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/mouse_delta_acc_sat_add.sv
// ============================================================================
// sat_add : signed 9-bit delta added into a W-bit accumulator, clamped
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sat_add
  import mouse_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] acc,
  input  logic [8:0]   delta,
  output logic [W-1:0] sum
);

  // One bit wider than the wider operand so the raw sum can never wrap.
  localparam int c_sw = ((W > 9) ? W : 9) + 1;
  localparam logic signed [c_sw-1:0] c_max = {{(c_sw-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [c_sw-1:0] c_min = {{(c_sw-W+1){1'b1}}, {(W-1){1'b0}}};

  delta_t                 w_d;
  logic signed [c_sw-1:0] w_acc_ext;
  logic signed [c_sw-1:0] w_d_ext;
  logic signed [c_sw-1:0] w_sum;

  assign w_d       = delta;
  assign w_acc_ext = {{(c_sw-W){acc[W-1]}}, acc};
  assign w_d_ext   = {{(c_sw-9){w_d[8]}}, w_d};
  assign w_sum     = w_acc_ext + w_d_ext;

  always_comb begin
    sum = w_sum[W-1:0];
    if (w_sum > c_max) begin
      sum = c_max[W-1:0];
    end else if (w_sum < c_min) begin
      sum = c_min[W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/mouse_delta_acc.sv
// ============================================================================
// mouse_delta_acc : PS/2 mouse packet decode into relative/absolute counters
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mouse_delta_acc
  import mouse_pkg::*;
#(
  parameter int ACC_W    = 8,
  parameter bit INVERT_Y = 1'b0
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [24:0]      ps2_mouse,
  input  logic             rd_x,
  input  logic             rd_y,
  output logic [ACC_W-1:0] rel_x,
  output logic [ACC_W-1:0] rel_y,
  output logic [7:0]       abs_x,
  output logic [7:0]       abs_y,
  output logic [2:0]       buttons,
  output logic             moved,
  output logic             pkt_stb
);

  logic             r_old_tog;
  logic             r_v1;
  delta_t           r_dx;
  delta_t           r_dy;
  logic [2:0]       r_btn;

  logic             w_new_pkt;
  delta_t           w_dx;
  delta_t           w_dy;
  delta_t           w_dy_adj;
  logic [ACC_W-1:0] w_acc_x;
  logic [ACC_W-1:0] w_acc_y;
  logic [ACC_W-1:0] w_sum_x;
  logic [ACC_W-1:0] w_sum_y;
  logic             w_unused_sync;

  // Status bit 3 is the PS/2 always-one sync bit and carries no information.
  assign w_unused_sync = ps2_mouse[3];

  assign w_new_pkt = ps2_mouse[TOG_BIT] != r_old_tog;
  assign w_dx = decode_axis(ps2_mouse[X_LSB +: 8], ps2_mouse[SX_BIT], ps2_mouse[OX_BIT]);
  assign w_dy = decode_axis(ps2_mouse[Y_LSB +: 8], ps2_mouse[SY_BIT], ps2_mouse[OY_BIT]);

  generate
    if (INVERT_Y) begin : g_inv_y
      assign w_dy_adj = negate_clamp(w_dy);
    end else begin : g_pass_y
      assign w_dy_adj = w_dy;
    end
  endgenerate

  // A read in the same cycle as an update restarts the sum from zero, so the
  // concurrent delta lands in the fresh accumulator exactly once.
  assign w_acc_x = rd_x ? '0 : rel_x;
  assign w_acc_y = rd_y ? '0 : rel_y;

  sat_add #(.W(ACC_W)) u_sat_x (
    .acc   (w_acc_x),
    .delta (r_dx),
    .sum   (w_sum_x)
  );

  sat_add #(.W(ACC_W)) u_sat_y (
    .acc   (w_acc_y),
    .delta (r_dy),
    .sum   (w_sum_y)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_old_tog <= ps2_mouse[TOG_BIT];
      r_v1      <= 1'b0;
      r_dx      <= '0;
      r_dy      <= '0;
      r_btn     <= '0;
      rel_x     <= '0;
      rel_y     <= '0;
      abs_x     <= '0;
      abs_y     <= '0;
      buttons   <= '0;
      moved     <= 1'b0;
      pkt_stb   <= 1'b0;
    end else begin
      r_old_tog <= ps2_mouse[TOG_BIT];
      r_v1      <= w_new_pkt;
      if (w_new_pkt) begin
        r_dx  <= w_dx;
        r_dy  <= w_dy_adj;
        r_btn <= ps2_mouse[2:0];
      end

      pkt_stb <= r_v1;

      if (r_v1) begin
        rel_x <= w_sum_x;
      end else if (rd_x) begin
        rel_x <= '0;
      end

      if (r_v1) begin
        rel_y <= w_sum_y;
      end else if (rd_y) begin
        rel_y <= '0;
      end

      if (r_v1) begin
        abs_x   <= abs_x + r_dx[7:0];
        abs_y   <= abs_y + r_dy[7:0];
        buttons <= r_btn;
      end

      if (r_v1 && ((r_dx != '0) || (r_dy != '0))) begin
        moved <= 1'b1;
      end else if (rd_x || rd_y) begin
        moved <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mouse_delta_acc.sv
// ============================================================================
// tb_mouse_delta_acc : scoreboard bench for mouse_delta_acc (plain and Y-inverted)
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mouse_delta_acc;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [24:0] ps2_mouse;
  logic        rd_x;
  logic        rd_y;
  logic [7:0]  rel_x, rel_y, abs_x, abs_y;
  logic [2:0]  buttons;
  logic        moved, pkt_stb;
  logic [7:0]  rel_x2, rel_y2, abs_x2, abs_y2;
  logic [2:0]  buttons2;
  logic        moved2, pkt_stb2;

  always #5 clk_sys = ~clk_sys;

  mouse_delta_acc #(.ACC_W(8), .INVERT_Y(1'b0)) dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_mouse(ps2_mouse), .rd_x(rd_x), .rd_y(rd_y),
    .rel_x(rel_x), .rel_y(rel_y), .abs_x(abs_x), .abs_y(abs_y),
    .buttons(buttons), .moved(moved), .pkt_stb(pkt_stb)
  );

  mouse_delta_acc #(.ACC_W(8), .INVERT_Y(1'b1)) dut_inv (
    .clk_sys(clk_sys), .reset(reset), .ps2_mouse(ps2_mouse), .rd_x(rd_x), .rd_y(rd_y),
    .rel_x(rel_x2), .rel_y(rel_y2), .abs_x(abs_x2), .abs_y(abs_y2),
    .buttons(buttons2), .moved(moved2), .pkt_stb(pkt_stb2)
  );

  typedef struct {
    int rx; int ry; int ax; int ay; int ry2; int ay2; int btn; int mv;
  } exp_t;

  exp_t q[$];
  int   rqx[$];
  int   rqy[$];
  int   rqy2[$];
  exp_t e;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what the counters should read once every issued packet has landed.
  int m_rx, m_ry, m_ry2, m_ax, m_ay, m_ay2, m_mv;
  bit sched_x = 1'b0;
  bit sched_y = 1'b0;

  function automatic int decode(input logic [7:0] m, input logic s, input logic o);
    if (o) return s ? -256 : 255;
    return s ? int'(m) - 256 : int'(m);
  endfunction

  function automatic int sat(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int wrap(input int v);
    return ((v % 256) + 256) % 256;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
    rd_x    = sched_x;
    rd_y    = sched_y;
    sched_x = 1'b0;
    sched_y = 1'b0;
  endtask

  // Issue one packet; rdx/rdy assert the read strobes in the cycle its update lands.
  task automatic send(input logic [7:0] y, input logic [7:0] x, input logic [7:0] st,
                      input bit rdx, input bit rdy);
    int   dx, dy, dy2;
    exp_t ex;
    dx  = decode(x, st[4], st[6]);
    dy  = decode(y, st[5], st[7]);
    dy2 = (-dy > 255) ? 255 : -dy;
    if (rdx) begin
      rqx.push_back(m_rx);
      m_rx = 0;
    end
    if (rdy) begin
      rqy.push_back(m_ry);
      rqy2.push_back(m_ry2);
      m_ry  = 0;
      m_ry2 = 0;
    end
    if (rdx || rdy) m_mv = 0;
    m_rx  = sat(m_rx + dx);
    m_ry  = sat(m_ry + dy);
    m_ry2 = sat(m_ry2 + dy2);
    m_ax  = wrap(m_ax + dx);
    m_ay  = wrap(m_ay + dy);
    m_ay2 = wrap(m_ay2 + dy2);
    if (dx != 0 || dy != 0) m_mv = 1;
    ex = '{rx: m_rx, ry: m_ry, ax: m_ax, ay: m_ay, ry2: m_ry2, ay2: m_ay2,
           btn: int'(st[2:0]), mv: m_mv};
    q.push_back(ex);
    ps2_mouse = {~ps2_mouse[24], y, x, st};
    sched_x   = rdx;
    sched_y   = rdy;
    tick();
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || rqx.size() != 0 || rqy.size() != 0) && n < 50) begin
      tick();
      n++;
    end
    if (q.size() != 0 || rqx.size() != 0 || rqy.size() != 0)
      chk("drain timeout (pending expectations)", q.size() + rqx.size() + rqy.size(), 0);
    tick();
    tick();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " rel_x"}, int'(rel_x), 0);
    chk({tag, " rel_y"}, int'(rel_y), 0);
    chk({tag, " abs_x"}, int'(abs_x), 0);
    chk({tag, " abs_y"}, int'(abs_y), 0);
    chk({tag, " buttons"}, int'(buttons), 0);
    chk({tag, " moved"}, int'(moved), 0);
    chk({tag, " rel_y inv"}, int'(rel_y2), 0);
    chk({tag, " abs_y inv"}, int'(abs_y2), 0);
  endtask

  task automatic do_reset(input bit flip_tog);
    reset = 1'b1;
    if (flip_tog) ps2_mouse = {~ps2_mouse[24], 24'h3C_55_13};
    tick();
    tick();
    m_rx = 0; m_ry = 0; m_ry2 = 0; m_ax = 0; m_ay = 0; m_ay2 = 0; m_mv = 0;
    q.delete();
    rqx.delete();
    rqy.delete();
    rqy2.delete();
    reset = 1'b0;
    tick();
  endtask

  // Scoreboard monitor: compares on every strobe/read, sampled mid-cycle.
  always @(negedge clk_sys) begin
    if (rd_x) begin
      if (rqx.size() == 0) chk("rd_x without expectation", int'(rd_x), 0);
      else chk("rel_x consumed on rd_x", int'($signed(rel_x)), rqx.pop_front());
    end
    if (rd_y) begin
      if (rqy.size() == 0) chk("rd_y without expectation", int'(rd_y), 0);
      else begin
        chk("rel_y consumed on rd_y", int'($signed(rel_y)), rqy.pop_front());
        chk("inv rel_y consumed on rd_y", int'($signed(rel_y2)), rqy2.pop_front());
      end
    end
    if (pkt_stb) begin
      if (q.size() == 0) chk("unexpected pkt_stb", int'(pkt_stb), 0);
      else begin
        e = q.pop_front();
        chk("rel_x", int'($signed(rel_x)), e.rx);
        chk("rel_y", int'($signed(rel_y)), e.ry);
        chk("abs_x", int'(abs_x), e.ax);
        chk("abs_y", int'(abs_y), e.ay);
        chk("buttons", int'(buttons), e.btn);
        chk("moved", int'(moved), e.mv);
        chk("inv pkt_stb", int'(pkt_stb2), 1);
        chk("inv rel_y", int'($signed(rel_y2)), e.ry2);
        chk("inv abs_y", int'(abs_y2), e.ay2);
      end
    end else if (pkt_stb2) begin
      chk("inv pkt_stb without plain pkt_stb", int'(pkt_stb2), 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    ps2_mouse = '0;
    rd_x      = 1'b0;
    rd_y      = 1'b0;
    do_reset(1'b0);
    check_zero("after reset");

    // Basic packet
    send(8'h05, 8'h10, 8'h01, 1'b0, 1'b0);
    drain();
    chk("basic rel_x", int'(rel_x), 16);
    chk("basic abs_y", int'(abs_y), 5);

    // Saturation of the relative counter while absolute wraps
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) send(8'h00, 8'h64, 8'h00, 1'b0, 1'b0);
    drain();
    chk("sat rel_x", int'(rel_x), 127);
    chk("wrap abs_x", int'(abs_x), 8'hE8);

    // Negative delta, then positive overflow
    do_reset(1'b0);
    send(8'h00, 8'hF0, 8'h10, 1'b0, 1'b0);
    drain();
    chk("neg rel_x", int'(rel_x), 8'hF0);
    send(8'h00, 8'h00, 8'h40, 1'b0, 1'b0);
    drain();
    chk("ovf rel_x", int'(rel_x), 127);
    chk("ovf abs_x", int'(abs_x), 8'hEF);

    // Read coinciding with an update
    do_reset(1'b0);
    send(8'h00, 8'd20, 8'h00, 1'b0, 1'b0);
    drain();
    send(8'h00, 8'd3, 8'h00, 1'b1, 1'b0);
    drain();
    chk("coincident rel_x", int'(rel_x), 3);
    chk("coincident moved", int'(moved), 1);
    send(8'h00, 8'h00, 8'h02, 1'b1, 1'b0);
    drain();
    chk("zero-delta read clears moved", int'(moved), 0);

    // Read strobe held for several cycles
    send(8'h07, 8'h09, 8'h00, 1'b0, 1'b0);
    drain();
    rqx.push_back(m_rx);
    rqx.push_back(0);
    rqx.push_back(0);
    m_rx = 0;
    m_mv = 0;
    for (int i = 0; i < 3; i++) begin
      sched_x = 1'b1;
      tick();
    end
    tick();
    tick();
    chk("held rd_x rel_x", int'(rel_x), 0);
    chk("held rd_x abs_x", int'(abs_x), m_ax);
    chk("held rd_x rel_y", int'($signed(rel_y)), m_ry);

    // Toggle change during reset must not produce a packet
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) tick();
    check_zero("tog during reset");

    // Reset while a packet is in flight
    ps2_mouse = {~ps2_mouse[24], 8'h11, 8'h22, 8'h07};
    tick();
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) tick();
    check_zero("reset mid-pipeline");

    // Inverted Y at the -256 boundary
    send(8'h00, 8'h00, 8'h20, 1'b0, 1'b0);
    drain();
    chk("inv rel_y clamp", int'(rel_y2), 127);
    chk("inv abs_y clamp", int'(abs_y2), 8'hFF);

    // Randomized traffic with back-to-back packets and coincident reads
    do_reset(1'b0);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      else send(8'($urandom), 8'($urandom), 8'($urandom),
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mouse_delta_acc.md
Name: mouse_delta_acc

Overview:
- Shared PS/2 mouse front-end sitting directly downstream of mist_io's `ps2_mouse` bus.
- Decodes each toggle-strobed mouse packet and sign-extends the X/Y movement.
- Maintains two sets of counters:
  - saturating read-and-clear relative accumulators, for Symbiface/Multiplay-style interfaces;
  - free-running wrapping absolute counters, for Kempston-style interfaces.
- Also provides button state and a sticky `moved` flag to the CPU-facing mouse decoders.

Parameters:
- ACC_W, 8: width of the signed relative accumulators; range −2^(ACC_W−1) .. 2^(ACC_W−1)−1.
- INVERT_Y, 0: 1 = negate Y delta before accumulation (CPC screen-down positive).

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ps2_mouse  in  25  [24] packet toggle, [23:16] Y, [15:8] X, [7:0] PS/2 status byte
- rd_x  in  1  one-cycle pulse: CPU consumed `rel_x`; clear it
- rd_y  in  1  one-cycle pulse: CPU consumed `rel_y`; clear it
- rel_x  out  ACC_W  signed accumulated X since last `rd_x`
- rel_y  out  ACC_W  signed accumulated Y since last `rd_y`
- abs_x  out  8  wrapping absolute X counter
- abs_y  out  8  wrapping absolute Y counter
- buttons  out  3  {middle, right, left} from last packet
- moved  out  1  sticky: nonzero delta since last read
- pkt_stb  out  1  one-cycle pulse when a packet is applied

Behaviour:
- Interface: one clock (`clk_sys`); reset is synchronous and active-high (`reset`).
- Reset state:
  - all outputs are 0;
  - the pipeline valid bits are cleared;
  - `old_tog` <= `ps2_mouse[24]`, so a toggle level present at reset never yields a packet.
- Stage 0 (cycle N):
  - `new_pkt` = `ps2_mouse[24]` != `old_tog`;
  - `old_tog` updates every cycle.
- Stage 1 (cycle N+1): register the decoded packet.
  - `dx` = {status[4], X}, 9-bit signed.
  - `dy` = {status[5], Y}, 9-bit signed.
  - If status[6] (X overflow) is set: `dx` = +255 when status[4]=0, else −256.
  - If status[7] (Y overflow) is set: same rule for `dy` using status[5].
  - If INVERT_Y: `dy` = −`dy`, computed in 10 bits and clamped to 9-bit range (+256 → +255).
  - Latch `btn` = status[2:0].
  - Set `v1`.
- Stage 2 (cycle N+2, when `v1`):
  - `rel` <= sat_add(`rel`, `d`), clamped to the ACC_W range.
  - `abs` <= `abs` + `d`[7:0], modulo 256.
  - `buttons` <= `btn`.
  - `pkt_stb` = 1 for exactly this cycle.
  - `moved` <= 1 if `dx` or `dy` is nonzero.
  - Latency: toggle edge to visible outputs is 2 cycles.
- Read-clear:
  - `rel_x` is a plain register; the value held in the `rd_x` cycle is the value consumed.
  - Next cycle, `rel_x` <= sat(0 + `dx`) if a stage-2 update coincides, else 0. A concurrent delta is never lost or double-counted.
  - Same for `rd_y`.
- `moved`:
  - cleared on `rd_x` or `rd_y`;
  - a coinciding nonzero update wins, leaving `moved` = 1.
- `abs_x`/`abs_y`: never cleared except by reset; unaffected by `rd_*`.
- Packet rate: back-to-back packets on consecutive cycles (toggle flipping every cycle) are each applied in order. The pipeline is one packet per cycle with no stall.
- Reset mid-pipeline: in-flight packets are discarded; no `pkt_stb` follows.
- `rd_x`/`rd_y` held high for several cycles: the accumulator is cleared every cycle. Only pulses are legal from decoders, but this must not corrupt `abs`.

Decomposition:
- Package `mouse_pkg`:
  - field-position constants: TOG_BIT = 24, Y_LSB = 16, X_LSB = 8, SX_BIT = 4, SY_BIT = 5, OX_BIT = 6, OY_BIT = 7;
  - typedef `delta_t` = logic signed [8:0].
- Sub-module `sat_add`: parameter W; combinational signed add of a 9-bit delta into a W-bit accumulator with clamping. Instantiated twice.
- Everything else stays in one module, roughly 150–200 lines.

Test Plan:
- Reset, then flip toggle with Y=0x05, X=0x10, status=0x01 → at N+2: `pkt_stb`=1, `rel_x`=16, `rel_y`=5, `abs_x`=0x10, `abs_y`=0x05, `buttons`=3'b001, `moved`=1.
- Ten packets of X=0x64 (+100), status=0x00 → `rel_x` saturates at 127; `abs_x` = 1000 mod 256 = 0xE8.
- X=0xF0 with status[4]=1 (−16) from zero → `rel_x`=0xF0 (−16), `abs_x`=0xF0. Then X overflow with sign 0 (+255) → `rel_x`=127, `abs_x`=0xEF.
- `rel_x`=20; `rd_x` asserted in the same cycle as the stage-2 update of +3 → 20 is held during the `rd_x` cycle; next cycle `rel_x`=3 and `moved`=1.
- `ps2_mouse[24]`=1 while `reset` is high, then `reset` released → no `pkt_stb`, outputs stay 0.
- Toggle flipped, then `reset` asserted at N+1 → no update and all outputs 0 after reset.
- INVERT_Y=1, Y=0x00 with status[5]=1 (−256) → `dy` clamps to +255, `rel_y`=127, `abs_y`=0xFF.
